// File: rtl/cpu_instr_sequencer.sv
// cpu_instr_sequencer
// Feeds 16-bit instructions from a host-filled FIFO into the Simple RISC
// Machine cpu through its in/load/s interface. The block uses the cpu's w
// signal to see when each instruction starts and when it completes. On
// completion it captures the cpu result and counts the instruction as retired.

module cpu_instr_sequencer #(
  parameter int DEPTH   = 8,
  parameter int TIMEOUT = 64
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     wr_en,
  input  logic [15:0]              wr_data,
  input  logic                     run,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic [15:0]              cpu_in,
  output logic                     cpu_load,
  output logic                     cpu_s,
  input  logic                     cpu_w,
  input  logic [15:0]              cpu_out,
  input  logic [2:0]               cpu_nvz,
  output logic                     res_valid,
  output logic [15:0]              res_data,
  output logic [2:0]               res_nvz,
  output logic [15:0]              retired,
  output logic                     err_timeout
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] COUNT_FULL = CW'(DEPTH);
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_ISSUE_S,
    S_WAIT_BUSY,
    S_WAIT_DONE,
    S_CAPTURE
  } state_t;

  state_t          r_state;
  state_t          w_nextState;
  logic [15:0]     r_mem [DEPTH];
  logic [PW-1:0]   r_wrPtr;
  logic [PW-1:0]   r_rdPtr;
  logic [CW-1:0]   r_count;
  logic            r_overflow;
  logic [TW-1:0]   r_timer;
  logic            r_errTimeout;
  logic            r_resValid;
  logic [15:0]     r_resData;
  logic [2:0]      r_resNvz;
  logic [15:0]     r_retired;

  logic            w_full;
  logic            w_empty;
  logic            w_push;
  logic            w_pop;
  logic            w_load;
  logic            w_sPulse;
  logic            w_capture;
  logic            w_timeoutHit;
  logic            w_timerExpired;

  assign w_full         = (r_count == COUNT_FULL);
  assign w_empty        = (r_count == '0);
  assign w_push         = wr_en && !w_full;
  assign w_pop          = (r_state == S_ISSUE_S) && !w_empty;
  assign w_timerExpired = (r_timer == TIMER_LAST);

  // FIFO storage: this is data only, so it needs no reset. The pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wrPtr] <= wr_data;
    end
  end

  // FIFO pointers, occupancy and the sticky overflow flag. Pointers wrap naturally because DEPTH is a power of 2.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wrPtr    <= '0;
      r_rdPtr    <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) begin
        r_wrPtr <= r_wrPtr + PW'(1);
      end
      if (w_pop) begin
        r_rdPtr <= r_rdPtr + PW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
      if (wr_en && w_full) begin
        r_overflow <= 1'b1;
      end
    end
  end

  // State register for the issue sequence.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state logic and the one-cycle load/s strobes. The strobes are decoded from the state, so reset drops them at once.
  always_comb begin
    w_nextState  = r_state;
    w_load       = 1'b0;
    w_sPulse     = 1'b0;
    w_capture    = 1'b0;
    w_timeoutHit = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (run && !w_empty && cpu_w && !r_errTimeout) begin
          w_nextState = S_LOAD;
        end
      end
      S_LOAD: begin
        w_load      = 1'b1;
        w_nextState = S_ISSUE_S;
      end
      S_ISSUE_S: begin
        w_sPulse    = 1'b1;
        w_nextState = S_WAIT_BUSY;
      end
      S_WAIT_BUSY: begin
        if (!cpu_w) begin
          w_nextState = S_WAIT_DONE;
        end else if (w_timerExpired) begin
          w_timeoutHit = 1'b1;
          w_nextState  = S_IDLE;
        end
      end
      S_WAIT_DONE: begin
        if (cpu_w) begin
          w_nextState = S_CAPTURE;
        end else if (w_timerExpired) begin
          w_timeoutHit = 1'b1;
          w_nextState  = S_IDLE;
        end
      end
      S_CAPTURE: begin
        w_capture   = 1'b1;
        w_nextState = S_IDLE;
      end
      default: begin
        w_nextState = S_IDLE;
      end
    endcase
  end

  // Wait timer. It restarts at issue and again when the cpu leaves wait, so each wait state has its own budget.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_timer <= '0;
    end else if (r_state == S_ISSUE_S || (r_state == S_WAIT_BUSY && !cpu_w)) begin
      r_timer <= '0;
    end else if (r_state == S_WAIT_BUSY || r_state == S_WAIT_DONE) begin
      r_timer <= r_timer + TW'(1);
    end
  end

  // Result capture, retire counter and sticky timeout error. After a timeout, nothing more is issued until reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_resValid   <= 1'b0;
      r_resData    <= '0;
      r_resNvz     <= '0;
      r_retired    <= '0;
      r_errTimeout <= 1'b0;
    end else begin
      r_resValid <= w_capture;
      if (w_capture) begin
        r_resData <= cpu_out;
        r_resNvz  <= cpu_nvz;
        r_retired <= r_retired + 16'd1;
      end
      if (w_timeoutHit) begin
        r_errTimeout <= 1'b1;
      end
    end
  end

  assign full        = w_full;
  assign empty       = w_empty;
  assign count       = r_count;
  assign overflow    = r_overflow;
  assign cpu_in      = w_empty ? 16'h0000 : r_mem[r_rdPtr];
  assign cpu_load    = w_load;
  assign cpu_s       = w_sPulse;
  assign res_valid   = r_resValid;
  assign res_data    = r_resData;
  assign res_nvz     = r_resNvz;
  assign retired     = r_retired;
  assign err_timeout = r_errTimeout;

endmodule
